// File: rtl/mc_pkg.sv
// mc_pkg: shared definitions for the multicycle control unit.
//   - state_t        : FSM state encodings (ADDI states only with MC_CONTROL_ADDI_EN)
//   - OP_*           : supported opcode field values
//   - ALUOP_*        : aluop codes sent to the ALU control unit (2'b11 is unused)
//   - PCSRC_*/ALUB_* : pcsource and alusrcb mux select encodings
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC    = 4'd6,
        S_RWB     = 4'd7,
        S_BEQ     = 4'd8,
        S_JUMP    = 4'd9
`ifdef MC_CONTROL_ADDI_EN
        ,
        S_ADDI_EX = 4'd10,
        S_ADDI_WB = 4'd11
`endif
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] ALUB_REG     = 2'b00;
    localparam logic [1:0] ALUB_FOUR    = 2'b01;
    localparam logic [1:0] ALUB_SEXT    = 2'b10;
    localparam logic [1:0] ALUB_SEXT_SH = 2'b11;

endpackage

// File: rtl/mc_outdec.sv
// mc_outdec: Moore output decoder for the multicycle control unit.
//   state     : low 4 bits of the current state
//   mem_ready : memory handshake; gates irwrite/pcwrite in FETCH
//   en        : low forces every control to 0 (reset / invalid state)
//   outputs   : datapath controls, mux selects and 2-bit aluop
// Macro MC_CONTROL_ADDI_EN adds the ADDI_EX/ADDI_WB decodes.
module mc_outdec
    import mc_pkg::*;
(
    input  logic [3:0] state,
    input  logic       mem_ready,
    input  logic       en,
    output logic       pcwrite,
    output logic       pcwritecond,
    output logic       iord,
    output logic       memread,
    output logic       memwrite,
    output logic       memtoreg,
    output logic       irwrite,
    output logic       alusrca,
    output logic       regwrite,
    output logic       regdst,
    output logic [1:0] pcsource,
    output logic [1:0] alusrcb,
    output logic [1:0] aluop
);

    always_comb begin
        pcwrite     = 1'b0;
        pcwritecond = 1'b0;
        iord        = 1'b0;
        memread     = 1'b0;
        memwrite    = 1'b0;
        memtoreg    = 1'b0;
        irwrite     = 1'b0;
        alusrca     = 1'b0;
        regwrite    = 1'b0;
        regdst      = 1'b0;
        pcsource    = PCSRC_ALU;
        alusrcb     = ALUB_REG;
        aluop       = ALUOP_ADD;
        if (en) begin
            case (state_t'(state))
                S_FETCH: begin
                    memread = 1'b1;
                    alusrcb = ALUB_FOUR;
                    irwrite = mem_ready;
                    pcwrite = mem_ready;
                end
                S_DECODE: alusrcb = ALUB_SEXT_SH;
                S_MEMADR: begin
                    alusrca = 1'b1;
                    alusrcb = ALUB_SEXT;
                end
                S_MEMRD: begin
                    memread = 1'b1;
                    iord    = 1'b1;
                end
                S_MEMWR: begin
                    memwrite = 1'b1;
                    iord     = 1'b1;
                end
                S_MEMWB: begin
                    regwrite = 1'b1;
                    memtoreg = 1'b1;
                end
                S_EXEC: begin
                    alusrca = 1'b1;
                    aluop   = ALUOP_FUNCT;
                end
                S_RWB: begin
                    regwrite = 1'b1;
                    regdst   = 1'b1;
                end
                S_BEQ: begin
                    alusrca     = 1'b1;
                    aluop       = ALUOP_SUB;
                    pcwritecond = 1'b1;
                    pcsource    = PCSRC_ALUOUT;
                end
                S_JUMP: begin
                    pcwrite  = 1'b1;
                    pcsource = PCSRC_JUMP;
                end
`ifdef MC_CONTROL_ADDI_EN
                S_ADDI_EX: begin
                    alusrca = 1'b1;
                    alusrcb = ALUB_SEXT;
                end
                S_ADDI_WB: regwrite = 1'b1;
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/mc_control.sv
// mc_control: multicycle MIPS-style control FSM (state register + next state).
//   clk, rst_n   : clock, asynchronous active-low reset
//   op           : instruction opcode field
//   mem_ready    : memory access completes this cycle
//   datapath controls, pcsource/alusrcb selects, aluop1/aluop0
//   illegal_op   : pulses in DECODE for an unsupported opcode
//   state        : current state (debug)
// Macro MC_CONTROL_ADDI_EN enables ADDI (op 001000); otherwise it is illegal.
module mc_control
    import mc_pkg::*;
#(
    parameter int STATE_W = 4   // must be >= 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         op,
    input  logic               mem_ready,
    output logic               pcwrite,
    output logic               pcwritecond,
    output logic               iord,
    output logic               memread,
    output logic               memwrite,
    output logic               memtoreg,
    output logic               irwrite,
    output logic               alusrca,
    output logic               regwrite,
    output logic               regdst,
    output logic [1:0]         pcsource,
    output logic [1:0]         alusrcb,
    output logic               aluop1,
    output logic               aluop0,
    output logic               illegal_op,
    output logic [STATE_W-1:0] state
);

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;
    logic               state_ok;
    logic               illegal;
    logic [1:0]         aluop;
    state_t             cur;
    state_t             nxt;

    // Encodings with any bit above bit 3 set are invalid and fall back to FETCH.
    assign state_ok = ((state_q >> 4) == '0);
    assign cur      = state_t'(state_q[3:0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= STATE_W'(S_FETCH);
        else        state_q <= state_d;
    end

    always_comb begin
        nxt     = S_FETCH;
        illegal = 1'b0;
        if (state_ok) begin
            case (cur)
                S_FETCH:  nxt = mem_ready ? S_DECODE : S_FETCH;
                S_DECODE: begin
                    case (op)
                        OP_RTYPE:      nxt = S_EXEC;
                        OP_LW, OP_SW:  nxt = S_MEMADR;
                        OP_BEQ:        nxt = S_BEQ;
                        OP_J:          nxt = S_JUMP;
`ifdef MC_CONTROL_ADDI_EN
                        OP_ADDI:       nxt = S_ADDI_EX;
`endif
                        default:       illegal = 1'b1;
                    endcase
                end
                S_MEMADR: nxt = (op == OP_LW) ? S_MEMRD : S_MEMWR;
                S_MEMRD:  nxt = mem_ready ? S_MEMWB : S_MEMRD;
                S_MEMWR:  nxt = mem_ready ? S_FETCH : S_MEMWR;
                S_EXEC:   nxt = S_RWB;
`ifdef MC_CONTROL_ADDI_EN
                S_ADDI_EX: nxt = S_ADDI_WB;
`endif
                default:  nxt = S_FETCH;
            endcase
        end
        state_d = STATE_W'(nxt);
    end

    mc_outdec u_outdec (
        .state       (state_q[3:0]),
        .mem_ready   (mem_ready),
        .en          (rst_n & state_ok),
        .pcwrite     (pcwrite),
        .pcwritecond (pcwritecond),
        .iord        (iord),
        .memread     (memread),
        .memwrite    (memwrite),
        .memtoreg    (memtoreg),
        .irwrite     (irwrite),
        .alusrca     (alusrca),
        .regwrite    (regwrite),
        .regdst      (regdst),
        .pcsource    (pcsource),
        .alusrcb     (alusrcb),
        .aluop       (aluop)
    );

    assign aluop1     = aluop[1];
    assign aluop0     = aluop[0];
    assign illegal_op = rst_n & illegal;
    assign state      = state_q;

endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control: directed and randomized checks of mc_control against an
// instruction-path reference model.
module tb_mc_control;

    typedef struct packed {
        logic       pcwrite, pcwritecond, iord, memread, memwrite, memtoreg;
        logic       irwrite, alusrca, regwrite, regdst;
        logic [1:0] pcsource, alusrcb, aluop;
        logic       illegal_op;
    } ctrl_t;

    typedef int q_t[$];

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] op;
    logic       mem_ready;
    logic       pcwrite, pcwritecond, iord, memread, memwrite, memtoreg;
    logic       irwrite, alusrca, regwrite, regdst, aluop1, aluop0, illegal_op;
    logic [1:0] pcsource, alusrcb;
    logic [3:0] dut_state;

    int errors = 0;
    int checks = 0;
    int m_state = 0;
    q_t plan;
    logic [5:0] cur_op;

    always #5 clk = ~clk;

    mc_control #(.STATE_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready),
        .pcwrite(pcwrite), .pcwritecond(pcwritecond), .iord(iord),
        .memread(memread), .memwrite(memwrite), .memtoreg(memtoreg),
        .irwrite(irwrite), .alusrca(alusrca), .regwrite(regwrite),
        .regdst(regdst), .pcsource(pcsource), .alusrcb(alusrcb),
        .aluop1(aluop1), .aluop0(aluop0), .illegal_op(illegal_op),
        .state(dut_state)
    );

    // States visited after DECODE for each instruction class.
    function automatic q_t path(input logic [5:0] o);
        q_t p;
        case (o)
            6'b000000: p = '{6, 7};
            6'b100011: p = '{2, 3, 4};
            6'b101011: p = '{2, 5};
            6'b000100: p = '{8};
            6'b000010: p = '{9};
`ifdef MC_CONTROL_ADDI_EN
            6'b001000: p = '{10, 11};
`endif
            default:   p = {};
        endcase
        return p;
    endfunction

    function automatic ctrl_t exp_ctrl(input int s, input logic m, input logic [5:0] o, input logic rn);
        ctrl_t c = '0;
        if (!rn) return c;
        case (s)
            0:  begin c.memread = 1; c.alusrcb = 2'b01; c.irwrite = m; c.pcwrite = m; end
            1:  begin c.alusrcb = 2'b11; c.illegal_op = (path(o).size() == 0); end
            2:  begin c.alusrca = 1; c.alusrcb = 2'b10; end
            3:  begin c.memread = 1; c.iord = 1; end
            4:  begin c.regwrite = 1; c.memtoreg = 1; end
            5:  begin c.memwrite = 1; c.iord = 1; end
            6:  begin c.alusrca = 1; c.aluop = 2'b10; end
            7:  begin c.regwrite = 1; c.regdst = 1; end
            8:  begin c.alusrca = 1; c.aluop = 2'b01; c.pcwritecond = 1; c.pcsource = 2'b01; end
            9:  begin c.pcwrite = 1; c.pcsource = 2'b10; end
            10: begin c.alusrca = 1; c.alusrcb = 2'b10; end
            11: c.regwrite = 1;
            default: ;
        endcase
        return c;
    endfunction

    task automatic model_step(input logic [5:0] o, input logic m);
        if (m_state == 0) begin
            m_state = m ? 1 : 0;
        end else if (m_state == 1) begin
            plan = path(o);
            m_state = (plan.size() != 0) ? plan.pop_front() : 0;
        end else if ((m_state == 3 || m_state == 5) && !m) begin
            m_state = m_state;
        end else begin
            m_state = (plan.size() != 0) ? plan.pop_front() : 0;
        end
    endtask

    task automatic check(input string tag);
        ctrl_t got, exp;
        exp = exp_ctrl(m_state, mem_ready, op, rst_n);
        got = '{pcwrite, pcwritecond, iord, memread, memwrite, memtoreg, irwrite,
                alusrca, regwrite, regdst, pcsource, alusrcb, {aluop1, aluop0}, illegal_op};
        checks++;
        assert (dut_state === 4'(m_state)) else begin
            errors++;
            $error("FAIL %s state: got %0d expected %0d", tag, dut_state, m_state);
        end
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s ctrl (state %0d): got %b expected %b", tag, m_state, got, exp);
        end
        checks++;
        assert (!(memread === 1'b1 && memwrite === 1'b1)) else begin
            errors++;
            $error("FAIL %s rd_wr_excl: got memread=%b memwrite=%b expected not both 1", tag, memread, memwrite);
        end
    endtask

    task automatic cyc(input logic [5:0] o, input logic m, input string tag);
        @(negedge clk);
        op = o;
        mem_ready = m;
        #1 check(tag);
        @(posedge clk);
        model_step(o, m);
    endtask

    function automatic logic [5:0] pick_op();
        logic [5:0] r;
        r = 6'($urandom());
        case ($urandom_range(0, 7))
            0: return 6'b000000;
            1: return 6'b100011;
            2: return 6'b101011;
            3: return 6'b000100;
            4: return 6'b000010;
            5: return 6'b001000;
            6: return 6'b111111;
            default: return r;
        endcase
    endfunction

    initial begin
        rst_n = 1'b0;
        op = '0;
        mem_ready = 1'b1;
        #3 check("reset");
        @(posedge clk);
        #1 check("reset_hold");
        rst_n = 1'b1;

        // R-type
        repeat (4) cyc(6'b000000, 1'b1, "rtype");
        // LW with a FETCH stall and 3 MEMRD stall cycles
        cyc(6'b100011, 1'b0, "lw_fetch_wait");
        repeat (3) cyc(6'b100011, 1'b1, "lw");
        repeat (3) cyc(6'b100011, 1'b0, "lw_memrd_wait");
        repeat (2) cyc(6'b100011, 1'b1, "lw_done");
        // SW
        repeat (4) cyc(6'b101011, 1'b1, "sw");
        // BEQ then J
        repeat (3) cyc(6'b000100, 1'b1, "beq");
        repeat (3) cyc(6'b000010, 1'b1, "jump");
        // Illegal opcode, then ADDI
        repeat (2) cyc(6'b111111, 1'b1, "illegal");
        cyc(6'b000000, 1'b1, "after_illegal");
        repeat (3) cyc(6'b000000, 1'b1, "rtype2");
        repeat (4) cyc(6'b001000, 1'b1, "addi");

        // Randomized instruction stream; op held for a whole instruction
        cur_op = pick_op();
        for (int i = 0; i < 600; i++) begin
            if (m_state == 0) cur_op = pick_op();
            cyc(cur_op, ($urandom_range(0, 3) != 0), "random");
        end
        while (m_state != 0) cyc(cur_op, 1'b1, "drain");

        // Reset in the middle of a stalled store
        repeat (3) cyc(6'b101011, 1'b1, "sw_pre_rst");
        cyc(6'b101011, 1'b0, "sw_memwr");
        #2 rst_n = 1'b0;
        #1;
        m_state = 0;
        plan.delete();
        check("rst_async");
        mem_ready = 1'b1;
        @(posedge clk);
        #1 check("rst_held");
        rst_n = 1'b1;
        repeat (3) cyc(6'b101011, 1'b0, "post_rst");
        repeat (4) cyc(6'b101011, 1'b1, "sw_after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mc_control.md
MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 SHALL have parameter STATE_W, default 4, the state register width; values below 4 are illegal.
REQ-002 SHALL have port clk, input, 1, the sole clock; all state changes occur on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, the reset; asynchronous and active-low.
REQ-004 SHALL have port op, input, 6, the opcode field of the instruction register.
REQ-005 SHALL have port mem_ready, input, 1, memory handshake; high means the current access completes this cycle.
REQ-006 SHALL have outputs pcwrite, pcwritecond, iord, memread, memwrite, memtoreg, irwrite, alusrca, regwrite, regdst, each 1 bit: standard multicycle datapath controls.
REQ-007 SHALL have outputs pcsource (2 bits) and alusrcb (2 bits): mux selects.
REQ-008 SHALL have outputs aluop1 and aluop0, 1 bit each, driving the ALU control unit.
REQ-009 SHALL have output illegal_op, 1 bit, a one-cycle pulse on an unsupported opcode.
REQ-010 SHALL have output state, STATE_W bits, the current state for debug.

Function
REQ-011 SHALL be a Moore FSM; outputs depend on state only, except for the mem_ready gating in REQ-013.
REQ-012 SHALL have states FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BEQ=8, JUMP=9, ADDI_EX=10, ADDI_WB=11; any other encoding SHALL go to FETCH on the next edge.
REQ-013 FETCH SHALL drive memread=1, alusrcb=01, aluop=00, pcsource=00, and irwrite=pcwrite=mem_ready; it SHALL hold until mem_ready=1, then go to DECODE.
REQ-014 DECODE SHALL drive alusrcb=11, aluop=00 and branch on op:
- 000000 -> EXEC
- 100011 or 101011 -> MEMADR
- 000100 -> BEQ
- 000010 -> JUMP
- 001000 -> ADDI_EX
- otherwise -> FETCH, with illegal_op=1 for that DECODE cycle.
REQ-015 MEMADR SHALL drive alusrca=1, alusrcb=10, aluop=00; it SHALL go to MEMRD if op=100011, else to MEMWR.
REQ-016 MEMRD SHALL drive memread=1, iord=1; it SHALL hold until mem_ready=1, then go to MEMWB.
REQ-017 MEMWR SHALL drive memwrite=1, iord=1; it SHALL hold until mem_ready=1, then go to FETCH.
REQ-018 MEMWB SHALL drive regwrite=1, memtoreg=1, regdst=0 -> FETCH.
REQ-019 EXEC SHALL drive alusrca=1, alusrcb=00, aluop=10 -> RWB; RWB SHALL drive regwrite=1, regdst=1, memtoreg=0 -> FETCH.
REQ-020 BEQ SHALL drive alusrca=1, alusrcb=00, aluop=01, pcwritecond=1, pcsource=01 -> FETCH.
REQ-021 JUMP SHALL drive pcwrite=1, pcsource=10 -> FETCH.
REQ-022 ADDI_EX SHALL drive alusrca=1, alusrcb=10, aluop=00 -> ADDI_WB; ADDI_WB SHALL drive regwrite=1, regdst=0, memtoreg=0 -> FETCH.
REQ-023 Every output not listed for a state SHALL be 0; aluop=11 SHALL never be driven.
REQ-024 memread and memwrite SHALL never be high in the same cycle.

Reset
REQ-025 rst_n low SHALL force state=FETCH immediately, without waiting for a clock edge.
REQ-026 While rst_n is low, all outputs except state SHALL be 0, including memread and irwrite.
REQ-027 Reset mid-access (MEMRD/MEMWR with mem_ready low) SHALL abandon the access with no write enable asserted.
REQ-028 FETCH behaviour SHALL begin on the first cycle after rst_n rises.

Configuration
REQ-029 Macro MC_CONTROL_ADDI_EN SHALL gate ADDI support. When defined, op 001000 SHALL follow REQ-014/REQ-022. When undefined, ADDI_EX and ADDI_WB SHALL be absent, and op 001000 SHALL be illegal (illegal_op pulse, return to FETCH).

Structure
REQ-030 Shared package mc_pkg SHALL hold the state encodings, opcode constants, aluop constants and the pcsource/alusrcb encodings.
REQ-031 A sub-module mc_outdec SHALL map state and mem_ready to the output controls; mc_control SHALL hold the state register and next-state logic.

Verification
REQ-032 Reset, then op=000000 with mem_ready=1 -> state sequence 0,1,6,7,0; aluop=10 in EXEC; regwrite=1, regdst=1 in RWB.
REQ-033 op=100011, mem_ready low for 3 cycles in MEMRD -> MEMRD held 4 cycles, then MEMWB with regwrite=1, memtoreg=1.
REQ-034 op=101011 -> sequence 0,1,2,5,0; memwrite=1 only in MEMWR; memread never high at the same time.
REQ-035 op=000100, then op=000010 -> BEQ drives aluop=01, pcwritecond=1, pcsource=01; JUMP drives pcwrite=1, pcsource=10.
REQ-036 op=111111 -> illegal_op=1 for exactly one cycle, return to FETCH. op=001000 -> reaches ADDI_WB when MC_CONTROL_ADDI_EN is defined, else raises illegal_op.
REQ-037 rst_n pulled low in MEMWR with mem_ready=0 -> state=0 with no clock edge, all controls 0, no memwrite after release.
